// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - pipeline request/response and memory-controller bus
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rd;
    logic        resp_fault;
    logic        mem_we;
    logic [31:0] mem_address;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport master (
        output req_valid, req_we, req_addr, req_wd, mem_rd,
        input  req_ready, stall, resp_valid, resp_rd, resp_fault,
        input  mem_we, mem_address, mem_wd
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wd, mem_rd,
        output req_ready, stall, resp_valid, resp_rd, resp_fault,
        output mem_we, mem_address, mem_wd
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - region-checked load/store sequencer between pipeline and memory controller
module mem_access_unit #(
    parameter int READ_LATENCY = 1,
    parameter int ROM_BASE     = 400,
    parameter int RAM_BASE     = 8500,
    parameter int SENO_BASE    = 138100,
    parameter int SENO_END     = 138400
) (
    input logic             clk,
    input logic             rst,
    mem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [31:0] ROM_LO   = 32'(ROM_BASE);
    localparam logic [31:0] RAM_LO   = 32'(RAM_BASE);
    localparam logic [31:0] SENO_LO  = 32'(SENO_BASE);
    localparam logic [31:0] SENO_HI  = 32'(SENO_END);
    localparam logic [2:0]  LAST_CNT = 3'(READ_LATENCY - 1);

    state_t      state, next_state;
    logic [2:0]  cnt;
    logic        we_q;
    logic        fault_q;
    logic [31:0] rd_q;
    logic [31:0] address_q;
    logic [31:0] wd_q;
    logic        legal;
    logic        accept;
    logic        ready;
    logic        mem_we_c;
    logic        resp_c;

    // Loads may touch ROM, RAM and the sine table; stores only RAM.
    assign legal = bus.req_we ? (bus.req_addr >= RAM_LO && bus.req_addr < SENO_LO)
                              : (bus.req_addr >= ROM_LO && bus.req_addr < SENO_HI);
    assign accept = (state == IDLE) && bus.req_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        mem_we_c   = 1'b0;
        resp_c     = 1'b0;
        case (state)
            IDLE: begin
                ready = rst;
                if (bus.req_valid) next_state = legal ? ISSUE : RESP;
            end
            ISSUE: begin
                mem_we_c   = we_q;
                next_state = we_q ? RESP : WAIT;
            end
            WAIT: begin
                if (cnt == LAST_CNT) next_state = RESP;
            end
            RESP: begin
                resp_c     = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= 3'd0;
            we_q      <= 1'b0;
            fault_q   <= 1'b0;
            rd_q      <= 32'd0;
            address_q <= 32'd0;
            wd_q      <= 32'd0;
        end else begin
            cnt <= (state == WAIT) ? cnt + 3'd1 : 3'd0;
            if (accept) begin
                we_q    <= bus.req_we;
                fault_q <= ~legal;
                rd_q    <= 32'd0;
                // Rejected requests never reach the controller, so the bus keeps the last issued values.
                if (legal) begin
                    address_q <= bus.req_addr;
                    wd_q      <= bus.req_wd;
                end
            end
            if (state == WAIT && cnt == LAST_CNT) rd_q <= bus.mem_rd;
        end
    end

    assign bus.req_ready   = ready;
    assign bus.stall       = bus.req_valid & ~ready;
    assign bus.mem_we      = mem_we_c;
    assign bus.mem_address = address_q;
    assign bus.mem_wd      = wd_q;
    assign bus.resp_valid  = resp_c;
    assign bus.resp_rd     = resp_c ? rd_q : 32'd0;
    assign bus.resp_fault  = resp_c & fault_q;
endmodule
